// File: rtl/univ_shift_counter_if.sv
// Control/data bundle for univ_shift_counter: operation controls in, register contents and
// serial-out/wrap flag back. WIDTH must match the attached univ_shift_counter instance.
interface univ_shift_counter_if #(
  parameter int WIDTH = 4
);
  logic             enb;
  logic             dir;
  logic             s_in;
  logic [1:0]       modo;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             s_out;

  modport master (
    output enb, dir, s_in, modo, d,
    input  q, s_out
  );

  modport slave (
    input  enb, dir, s_in, modo, d,
    output q, s_out
  );
endinterface

// File: rtl/univ_shift_counter.sv
// WIDTH-bit universal register: shift, rotate, parallel load, up/down count with serial-out/wrap flag.
// Optional macro USR_SAT_EN: count mode saturates at 0 / all-ones instead of wrapping.
module univ_shift_counter #(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  univ_shift_counter_if.slave bus_if
);

  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;

  logic [WIDTH-1:0] q_q, q_d;
  logic             s_out_q, s_out_d;

  logic [WIDTH-1:0] shl_v, shr_v;
  logic [WIDTH-1:0] q_inc, q_dec;
  logic             fill_l, fill_r;
  logic             all_ones, all_zero;

  // Shift and rotate share one datapath; only the bit entering the vacated end differs.
  assign fill_l = (bus_if.modo == MODE_ROT) ? q_q[WIDTH-1] : bus_if.s_in;
  assign fill_r = (bus_if.modo == MODE_ROT) ? q_q[0]       : bus_if.s_in;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_nb
      if (gi == 0) begin : g_lsb
        assign shl_v[gi] = fill_l;
        assign shr_v[gi] = q_q[gi+1];
      end else if (gi == WIDTH - 1) begin : g_msb
        assign shl_v[gi] = q_q[gi-1];
        assign shr_v[gi] = fill_r;
      end else begin : g_mid
        assign shl_v[gi] = q_q[gi-1];
        assign shr_v[gi] = q_q[gi+1];
      end
    end
  endgenerate

  assign q_inc    = q_q + WIDTH'(1);
  assign q_dec    = q_q - WIDTH'(1);
  assign all_ones = &q_q;
  assign all_zero = ~|q_q;

  always_comb begin
    q_d     = q_q;
    s_out_d = 1'b0;
    if (bus_if.enb) begin
      case (bus_if.modo)
        MODE_SHIFT, MODE_ROT: begin
          if (!bus_if.dir) begin
            q_d     = shl_v;
            s_out_d = q_q[WIDTH-1];
          end else begin
            q_d     = shr_v;
            s_out_d = q_q[0];
          end
        end
        MODE_LOAD: begin
          q_d = bus_if.d;
        end
        default: begin
`ifdef USR_SAT_EN
          // Flag marks an edge where the step was blocked at the limit.
          if (!bus_if.dir) begin
            q_d     = all_ones ? q_q : q_inc;
            s_out_d = all_ones;
          end else begin
            q_d     = all_zero ? q_q : q_dec;
            s_out_d = all_zero;
          end
`else
          // Flag pulses on the wrap edge only.
          if (!bus_if.dir) begin
            q_d     = q_inc;
            s_out_d = all_ones;
          end else begin
            q_d     = q_dec;
            s_out_d = all_zero;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= RESET_VAL;
      s_out_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
    end
  end

  assign bus_if.q     = q_q;
  assign bus_if.s_out = s_out_q;

endmodule

// File: tb/tb_univ_shift_counter.sv
// Directed plus randomized checks of univ_shift_counter (WIDTH=4 and WIDTH=8/RESET_VAL=0x80)
// against an arithmetic reference model.
module tb_univ_shift_counter;

  logic clk;
  logic rst_n;

  int checks;
  int errors;
  int m_q;
  int m_s;

  univ_shift_counter_if #(.WIDTH(4)) bus4 ();
  univ_shift_counter_if #(.WIDTH(8)) bus8 ();

  univ_shift_counter #(.WIDTH(4), .RESET_VAL(4'h0)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus4)
  );

  univ_shift_counter #(.WIDTH(8), .RESET_VAL(8'h80)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model for WIDTH=4, written as plain integer arithmetic on the value.
  function automatic void model_next(input int e, input int dr, input int si, input int m, input int dd);
    int n;
    int half;
    int nq;
    int ns;
    n    = 16;
    half = n / 2;
    nq   = m_q;
    ns   = 0;
    if (e != 0) begin
      case (m)
        0: begin
          if (dr == 0) begin
            nq = (m_q * 2) % n + si;
            ns = m_q / half;
          end else begin
            nq = m_q / 2 + si * half;
            ns = m_q % 2;
          end
        end
        1: begin
          if (dr == 0) begin
            nq = (m_q * 2) % n + m_q / half;
            ns = m_q / half;
          end else begin
            nq = m_q / 2 + (m_q % 2) * half;
            ns = m_q % 2;
          end
        end
        2: begin
          nq = dd;
        end
        default: begin
`ifdef USR_SAT_EN
          if (dr == 0) begin
            nq = (m_q == n - 1) ? m_q : m_q + 1;
            ns = (m_q == n - 1) ? 1 : 0;
          end else begin
            nq = (m_q == 0) ? 0 : m_q - 1;
            ns = (m_q == 0) ? 1 : 0;
          end
`else
          if (dr == 0) begin
            nq = (m_q + 1) % n;
            ns = (m_q == n - 1) ? 1 : 0;
          end else begin
            nq = (m_q + n - 1) % n;
            ns = (m_q == 0) ? 1 : 0;
          end
`endif
        end
      endcase
    end
    m_q = nq;
    m_s = ns;
  endfunction

  task automatic step(input logic e, input logic dr, input logic si, input logic [1:0] m,
                      input logic [3:0] dd, input string tag);
    bus4.enb  = e;
    bus4.dir  = dr;
    bus4.s_in = si;
    bus4.modo = m;
    bus4.d    = dd;
    model_next(int'(e), int'(dr), int'(si), int'(m), int'(dd));
    @(posedge clk);
    #1;
    $display("%s en=%0b modo=%0d dir=%0b sin=%0b d=%h -> q=%h s_out=%b (model q=%h s_out=%0d)",
             tag, e, m, dr, si, dd, bus4.q, bus4.s_out, m_q[3:0], m_s);
    check({tag, "_q"}, 32'(bus4.q), 32'(m_q));
    check({tag, "_s"}, 32'(bus4.s_out), 32'(m_s));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_q    = 0;
    m_s    = 0;
    rst_n  = 1'b0;
    bus4.enb = 1'b0; bus4.dir = 1'b0; bus4.s_in = 1'b0; bus4.modo = 2'b00; bus4.d = 4'h0;
    bus8.enb = 1'b0; bus8.dir = 1'b0; bus8.s_in = 1'b0; bus8.modo = 2'b00; bus8.d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst4_q", 32'(bus4.q), 32'h0);
    check("rst4_s", 32'(bus4.s_out), 32'h0);
    check("rst8_q", 32'(bus8.q), 32'h80);
    check("rst8_s", 32'(bus8.s_out), 32'h0);
    rst_n = 1'b1;

    // WIDTH=8: shift right S_IN=0 eight times from 0x80
    bus8.enb = 1'b1; bus8.modo = 2'b00; bus8.dir = 1'b1; bus8.s_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      $display("w8 shr k=%0d -> q=%h s_out=%b", k, bus8.q, bus8.s_out);
      check("w8_shr_q", 32'(bus8.q), 32'(8'h80 >> k));
      check("w8_shr_s", 32'(bus8.s_out), (k == 8) ? 32'h1 : 32'h0);
    end
    bus8.enb = 1'b0;

    // Mid-count asynchronous reset at Q=0x9
    step(1'b1, 1'b0, 1'b0, 2'b10, 4'h8, "ld8");
    step(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, "up9");
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-cycle -> q=%h s_out=%b", bus4.q, bus4.s_out);
    check("arst_q", 32'(bus4.q), 32'h0);
    check("arst_s", 32'(bus4.s_out), 32'h0);
    m_q = 0;
    m_s = 0;
    @(posedge clk);
    #1;
    check("arst_hold_q", 32'(bus4.q), 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, "resume_up");

    // Load then shift left with S_IN=1
    step(1'b1, 1'b0, 1'b0, 2'b10, 4'hA, "ldA");
    step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, "shl1");
    step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, "shl2");

    // Rotate right from 0x9, then a disabled edge
    step(1'b1, 1'b0, 1'b0, 2'b10, 4'h9, "ld9");
    step(1'b1, 1'b1, 1'b0, 2'b01, 4'h0, "rotr");
    step(1'b0, 1'b1, 1'b1, 2'b10, 4'h3, "hold");

    // Count up across all-ones
    step(1'b1, 1'b0, 1'b0, 2'b10, 4'hE, "ldE");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, "cnt_up");

    // Count down across zero
    step(1'b1, 1'b0, 1'b0, 2'b10, 4'h1, "ld1");
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 1'b0, 2'b11, 4'h0, "cnt_dn");

    // Rotate left and shift right for the remaining directions
    step(1'b1, 1'b0, 1'b0, 2'b10, 4'hC, "ldC");
    step(1'b1, 1'b0, 1'b0, 2'b01, 4'h0, "rotl");
    step(1'b1, 1'b1, 1'b1, 2'b00, 4'h0, "shr1");

    // Randomized operations
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
